// File: rtl/video_pkg.sv
// Shared video timing types and mode constants.
// Exports: COORD_W, video_timing_t, VT_640X480, VT_1280X720, h_total(), v_total().
package video_pkg;

  localparam int COORD_W = 12;

  // Fields are one bit wider than a coordinate so a 4096 span fits.
  typedef struct packed {
    logic [COORD_W:0] h_active;
    logic [COORD_W:0] h_front;
    logic [COORD_W:0] h_sync;
    logic [COORD_W:0] h_back;
    logic [COORD_W:0] v_active;
    logic [COORD_W:0] v_front;
    logic [COORD_W:0] v_sync;
    logic [COORD_W:0] v_back;
    logic             h_pol;
    logic             v_pol;
  } video_timing_t;

  localparam video_timing_t VT_640X480 = '{
    h_active: 13'd640,
    h_front:  13'd16,
    h_sync:   13'd96,
    h_back:   13'd48,
    v_active: 13'd480,
    v_front:  13'd10,
    v_sync:   13'd2,
    v_back:   13'd33,
    h_pol:    1'b0,
    v_pol:    1'b0
  };

  localparam video_timing_t VT_1280X720 = '{
    h_active: 13'd1280,
    h_front:  13'd110,
    h_sync:   13'd40,
    h_back:   13'd220,
    v_active: 13'd720,
    v_front:  13'd5,
    v_sync:   13'd5,
    v_back:   13'd20,
    h_pol:    1'b1,
    v_pol:    1'b1
  };

  function automatic int h_total(video_timing_t t);
    return int'(t.h_active) + int'(t.h_front)
         + int'(t.h_sync) + int'(t.h_back);
  endfunction

  function automatic int v_total(video_timing_t t);
    return int'(t.v_active) + int'(t.v_front)
         + int'(t.v_sync) + int'(t.v_back);
  endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth register delay line with async active-low reset.
// Ports: clk, rst_n, din[WIDTH] -> dout[WIDTH] after DEPTH cycles.
module sig_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RESET_VAL;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: stage-0 coordinates/fetch plus delayed syncs.
// Ports: pixel_clk_i, rstn_i, en_i -> x_o, y_o, fetch_o, line/frame_start_o, hsync_o, vsync_o, draw_area_o.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE   = int'(VT_640X480.h_active),
  parameter int H_FRONT    = int'(VT_640X480.h_front),
  parameter int H_SYNC     = int'(VT_640X480.h_sync),
  parameter int H_BACK     = int'(VT_640X480.h_back),
  parameter int V_ACTIVE   = int'(VT_640X480.v_active),
  parameter int V_FRONT    = int'(VT_640X480.v_front),
  parameter int V_SYNC     = int'(VT_640X480.v_sync),
  parameter int V_BACK     = int'(VT_640X480.v_back),
  parameter bit H_POL      = VT_640X480.h_pol,
  parameter bit V_POL      = VT_640X480.v_pol,
  parameter int PIPE_DEPTH = 2
) (
  input  logic               pixel_clk_i,
  input  logic               rstn_i,
  input  logic               en_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               fetch_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               draw_area_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int CW      = COORD_W + 1;

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
    $error("video_timing_gen: H_TOTAL/V_TOTAL exceeds 4096");
  end

  if (H_TOTAL < 1 || V_TOTAL < 1) begin : g_bad_empty
    $error("video_timing_gen: empty raster");
  end

  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8) begin : g_bad_pipe
    $error("video_timing_gen: PIPE_DEPTH must be 1..8");
  end

  // Comparison bounds carry one extra bit so a full 4096 span
  // does not alias to zero.
  localparam logic [CW-1:0] HA  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS0 = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS1 = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VA  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS0 = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS1 = CW'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

  logic               run;
  logic               go;
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic [CW-1:0]      h_ext;
  logic [CW-1:0]      v_ext;
  logic               h_wrap;
  logic               v_wrap;
  logic               active;
  logic               hs;
  logic               vs;
  logic               hs_d;
  logic               vs_d;
  logic               active_d;

  // The registered run flag makes the first enabled cycle after
  // reset (or after a disable) sit at the origin.
  always_ff @(posedge pixel_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      run <= 1'b0;
    end else begin
      run <= en_i;
    end
  end

  assign go     = en_i & run;
  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge pixel_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!go) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + ONE;
    end else begin
      h_cnt <= h_cnt + ONE;
    end
  end

  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};

  assign active = go & (h_ext < HA) & (v_ext < VA);
  assign hs     = go & (h_ext >= HS0) & (h_ext < HS1);
  assign vs     = go & (v_ext >= VS0) & (v_ext < VS1);

  assign x_o           = h_cnt;
  assign y_o           = v_cnt;
  assign fetch_o       = active;
  assign line_start_o  = go & (h_cnt == '0) & (v_ext < VA);
  assign frame_start_o = go & (h_cnt == '0) & (v_cnt == '0);

  // Syncs travel as "asserted" flags and get their polarity at the
  // output, so an idle (reset) stage is simply all zeros.
  sig_delay #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DEPTH),
    .RESET_VAL (3'b000)
  ) u_delay (
    .clk   (pixel_clk_i),
    .rst_n (rstn_i),
    .din   ({hs, vs, active}),
    .dout  ({hs_d, vs_d, active_d})
  );

  assign hsync_o     = hs_d ? H_POL : ~H_POL;
  assign vsync_o     = vs_d ? V_POL : ~V_POL;
  assign draw_area_o = active_d;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default, small (PIPE 3) and tiny modes
// run in parallel against a cycle-count raster model.
module tb_video_timing_gen;
  import video_pkg::*;

  localparam int NI = 3;

  localparam video_timing_t VT_SMALL = '{
    h_active: 13'd64, h_front: 13'd4,
    h_sync: 13'd8, h_back: 13'd4,
    v_active: 13'd48, v_front: 13'd2,
    v_sync: 13'd2, v_back: 13'd3,
    h_pol: 1'b0, v_pol: 1'b0
  };

  localparam video_timing_t VT_TINY = '{
    h_active: 13'd4, h_front: 13'd1,
    h_sync: 13'd2, h_back: 13'd1,
    v_active: 13'd2, v_front: 13'd1,
    v_sync: 13'd1, v_back: 13'd1,
    h_pol: 1'b1, v_pol: 1'b1
  };

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        f;
    logic        ls;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        da;
  } obs_t;

  typedef struct {
    int k;
    int x;
    int y;
    bit fs;
    bit ls;
    bit f;
    bit hs;
    bit vs;
    bit da;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic en   = 1'b0;

  logic [11:0] xs [NI];
  logic [11:0] ys [NI];
  logic fe  [NI];
  logic lss [NI];
  logic fss [NI];
  logic hso [NI];
  logic vso [NI];
  logic das [NI];

  int checks = 0;
  int errors = 0;

  video_timing_t md [NI];
  int            pd [NI];
  int            kc;
  bit            run_m;
  logic [2:0]    hist [NI][8];
  bit            lock_on = 1'b0;

  logic [4:0] fh;
  logic       daprev;
  logic       vprev;
  int         xh [4];
  int         yh [4];

  always #5 clk = ~clk;

  video_timing_gen u_def (
    .pixel_clk_i   (clk),
    .rstn_i        (rstn),
    .en_i          (en),
    .x_o           (xs[0]),
    .y_o           (ys[0]),
    .fetch_o       (fe[0]),
    .line_start_o  (lss[0]),
    .frame_start_o (fss[0]),
    .hsync_o       (hso[0]),
    .vsync_o       (vso[0]),
    .draw_area_o   (das[0])
  );

  video_timing_gen #(
    .H_ACTIVE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_ACTIVE(48), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .H_POL(1'b0), .V_POL(1'b0), .PIPE_DEPTH(3)
  ) u_small (
    .pixel_clk_i   (clk),
    .rstn_i        (rstn),
    .en_i          (en),
    .x_o           (xs[1]),
    .y_o           (ys[1]),
    .fetch_o       (fe[1]),
    .line_start_o  (lss[1]),
    .frame_start_o (fss[1]),
    .hsync_o       (hso[1]),
    .vsync_o       (vso[1]),
    .draw_area_o   (das[1])
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1'b1), .V_POL(1'b1), .PIPE_DEPTH(2)
  ) u_tiny (
    .pixel_clk_i   (clk),
    .rstn_i        (rstn),
    .en_i          (en),
    .x_o           (xs[2]),
    .y_o           (ys[2]),
    .fetch_o       (fe[2]),
    .line_start_o  (lss[2]),
    .frame_start_o (fss[2]),
    .hsync_o       (hso[2]),
    .vsync_o       (vso[2]),
    .draw_area_o   (das[2])
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // {hs, vs, active} asserted flags for a raster position.
  function automatic logic [2:0] stage0(video_timing_t m,
                                        int x, int y, bit q);
    int ha;
    int va;
    int h0;
    int v0;
    logic [2:0] s;
    ha = int'(m.h_active);
    va = int'(m.v_active);
    h0 = ha + int'(m.h_front);
    v0 = va + int'(m.v_front);
    s[2] = q && x >= h0 && x < h0 + int'(m.h_sync);
    s[1] = q && y >= v0 && y < v0 + int'(m.v_sync);
    s[0] = q && x < ha && y < va;
    return s;
  endfunction

  // kc counts enabled cycles since the raster last restarted.
  function automatic obs_t expect_obs(int i);
    obs_t e;
    int x;
    int y;
    bit q;
    logic [2:0] s;
    logic [2:0] d;
    x = kc % h_total(md[i]);
    y = (kc / h_total(md[i])) % v_total(md[i]);
    q = en && run_m;
    s = stage0(md[i], x, y, q);
    d = hist[i][pd[i]-1];
    e.x  = 12'(x);
    e.y  = 12'(y);
    e.f  = s[0];
    e.ls = q && x == 0 && y < int'(md[i].v_active);
    e.fs = q && x == 0 && y == 0;
    e.hs = d[2] ? md[i].h_pol : ~md[i].h_pol;
    e.vs = d[1] ? md[i].v_pol : ~md[i].v_pol;
    e.da = d[0];
    return e;
  endfunction

  task automatic model_reset();
    kc    = 0;
    run_m = 1'b0;
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < 8; j++)
        hist[i][j] = 3'b000;
  endtask

  always @(negedge rstn) model_reset();

  always @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < NI; i++) begin
        int x;
        int y;
        x = kc % h_total(md[i]);
        y = (kc / h_total(md[i])) % v_total(md[i]);
        for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = stage0(md[i], x, y, en && run_m);
      end
      kc    = (en && run_m) ? kc + 1 : 0;
      run_m = en;
    end
  end

  always @(negedge clk) begin
    if (lock_on) begin
      for (int i = 0; i < NI; i++) begin
        obs_t a;
        obs_t e;
        a = '{x: xs[i], y: ys[i], f: fe[i], ls: lss[i],
              fs: fss[i], hs: hso[i], vs: vso[i], da: das[i]};
        e = expect_obs(i);
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL model[%0d]: got %h expected %h (t=%0t)",
                   i, a, e, $time);
        end
      end
    end
  end

  task automatic tick1();
    daprev = das[1];
    vprev  = vso[1];
    for (int j = 3; j > 0; j--) begin
      xh[j] = xh[j-1];
      yh[j] = yh[j-1];
    end
    @(negedge clk);
    fh    = {fh[3:0], fe[1]};
    xh[0] = int'(xs[1]);
    yh[0] = int'(ys[1]);
  endtask

  task automatic wait_def_x(input int xv, input int lim,
                            input string nm);
    int n;
    n = 0;
    while (xs[0] !== 12'(xv) && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(nm, xs[0] == 12'(xv), 1);
  endtask

  task automatic check_reset_def(input string nm);
    check({nm, "_x"},  xs[0],  0);
    check({nm, "_y"},  ys[0],  0);
    check({nm, "_f"},  fe[0],  0);
    check({nm, "_fs"}, fss[0], 0);
    check({nm, "_ls"}, lss[0], 0);
    check({nm, "_da"}, das[0], 0);
    check({nm, "_hs"}, hso[0], 1);
    check({nm, "_vs"}, vso[0], 1);
  endtask

  initial begin
    vec_t tv [16];
    int   cur;
    int   n;
    int   nf;
    int   nl;
    int   nv;
    int   per;
    int   r;

    md[0] = VT_640X480; pd[0] = 2;
    md[1] = VT_SMALL;   pd[1] = 3;
    md[2] = VT_TINY;    pd[2] = 2;
    model_reset();
    fh = '0;
    for (int j = 0; j < 4; j++) begin
      xh[j] = 0;
      yh[j] = 0;
    end

    // Tiny mode, k = enabled cycles since (0,0):
    //           k   x  y fs ls f hs vs da
    tv[0]  = '{  0, 0, 0, 1, 1, 1, 0, 0, 0};
    tv[1]  = '{  2, 2, 0, 0, 0, 1, 0, 0, 1};
    tv[2]  = '{  5, 5, 0, 0, 0, 0, 0, 0, 1};
    tv[3]  = '{  6, 6, 0, 0, 0, 0, 0, 0, 0};
    tv[4]  = '{  7, 7, 0, 0, 0, 0, 1, 0, 0};
    tv[5]  = '{  8, 0, 1, 0, 1, 1, 1, 0, 0};
    tv[6]  = '{  9, 1, 1, 0, 0, 1, 0, 0, 0};
    tv[7]  = '{ 10, 2, 1, 0, 0, 1, 0, 0, 1};
    tv[8]  = '{ 16, 0, 2, 0, 0, 0, 1, 0, 0};
    tv[9]  = '{ 24, 0, 3, 0, 0, 0, 1, 0, 0};
    tv[10] = '{ 26, 2, 3, 0, 0, 0, 0, 1, 0};
    tv[11] = '{ 33, 1, 4, 0, 0, 0, 0, 1, 0};
    tv[12] = '{ 34, 2, 4, 0, 0, 0, 0, 0, 0};
    tv[13] = '{ 39, 7, 4, 0, 0, 0, 1, 0, 0};
    tv[14] = '{ 40, 0, 0, 1, 1, 1, 1, 0, 0};
    tv[15] = '{ 42, 2, 0, 0, 0, 1, 0, 0, 1};

    lock_on = 1'b1;
    en = 1'b1;
    #1 rstn = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_reset_def("rst");
    end

    @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("first_x",  xs[0],  0);
    check("first_y",  ys[0],  0);
    check("first_fs", fss[0], 1);
    check("first_f",  fe[0],  1);

    cur = 0;
    for (int i = 0; i < 16; i++) begin
      repeat (tv[i].k - cur) @(negedge clk);
      cur = tv[i].k;
      check($sformatf("tiny%0d_x", i),  xs[2],  tv[i].x);
      check($sformatf("tiny%0d_y", i),  ys[2],  tv[i].y);
      check($sformatf("tiny%0d_fs", i), fss[2], tv[i].fs);
      check($sformatf("tiny%0d_ls", i), lss[2], tv[i].ls);
      check($sformatf("tiny%0d_f", i),  fe[2],  tv[i].f);
      check($sformatf("tiny%0d_hs", i), hso[2], tv[i].hs);
      check($sformatf("tiny%0d_vs", i), vso[2], tv[i].vs);
      check($sformatf("tiny%0d_da", i), das[2], tv[i].da);
    end

    // Default hsync: low for 96 cycles, starting 2 after x=656.
    wait_def_x(656, 2000, "wait_x656");
    @(negedge clk);
    check("hs_pre", hso[0], 1);
    @(negedge clk);
    check("hs_fall", hso[0], 0);
    n = 0;
    while (hso[0] === 1'b0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("hs_width", n, 96);

    // Small mode (PIPE_DEPTH 3): two whole frames.
    n = 0;
    while (fss[1] !== 1'b1 && n < 5000) begin
      tick1();
      n++;
    end
    check("wait_small_fs", fss[1], 1);
    for (int fr = 0; fr < 2; fr++) begin
      nf = 0;
      nl = 0;
      nv = 0;
      per = 0;
      do begin
        nf += int'(fe[1]);
        nl += int'(lss[1]);
        nv += int'(vso[1] == 1'b0);
        if (vso[1] == 1'b0 && vprev == 1'b1) begin
          check("vs_start_x", xh[3], 0);
          check("vs_start_y", yh[3], 50);
        end
        if (das[1] !== daprev)
          check("da_edge", {fh[4], fh[3]}, {daprev, das[1]});
        tick1();
        per++;
      end while (fss[1] !== 1'b1 && per < 6000);
      check("frame_period", per, 4400);
      check("frame_fetch",  nf,  64 * 48);
      check("frame_lines",  nl,  48);
      check("frame_vs_low", nv,  2 * 80);
    end

    // Disable mid-line, then re-enable.
    wait_def_x(99, 2000, "wait_x99");
    @(posedge clk);
    #2 en = 1'b0;
    @(negedge clk);
    check("drop_x",   xs[0],  100);
    check("drop_f",   fe[0],  0);
    check("drop_da0", das[0], 1);
    @(negedge clk);
    check("drop_nx",  xs[0],  0);
    check("drop_ny",  ys[0],  0);
    check("drop_nf",  fe[0],  0);
    check("drop_da1", das[0], 1);
    @(negedge clk);
    check("drop_da2", das[0], 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reen_fs", fss[0], 1);
    check("reen_x",  xs[0],  0);
    check("reen_y",  ys[0],  0);
    check("reen_f",  fe[0],  1);

    // Asynchronous reset mid-line.
    wait_def_x(299, 2000, "wait_x299");
    @(posedge clk);
    #2 rstn = 1'b0;
    @(negedge clk);
    check_reset_def("arst");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("arst_rel_x",  xs[0],  0);
    check("arst_rel_y",  ys[0],  0);
    check("arst_rel_fs", fss[0], 1);

    // Random enable/reset traffic against the model.
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      #2;
      r = int'($urandom_range(0, 999));
      if (!rstn) rstn = 1'b1;
      else if (r >= 997) rstn = 1'b0;
      if (en && r < 8) en = 1'b0;
      else if (!en && r < 300) en = 1'b1;
    end
    @(negedge clk);
    lock_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
